// File: rtl/ra_pkg.sv
// Shared types and default sizing for the rolling-average sequencer.
package ra_pkg;

    localparam int RA_SIZE_DEF       = 8;
    localparam int BITS_PER_ELEM_DEF = 5;
    localparam int CNT_W             = $clog2(RA_SIZE_DEF + 1);
    localparam int FLUSH_PAIRS       = RA_SIZE_DEF + 1;

    typedef logic [BITS_PER_ELEM_DEF-1:0] ra_sample_t;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CALC,
        FL_SHIFT,
        FL_CALC
    } ra_seq_state_t;

endpackage

// File: rtl/ra_sequencer_edge_sync.sv
// Multi-flop synchroniser for an asynchronous strobe, followed by a
// single-cycle rising-edge detector on the synchronised level.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign o_rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ra_sequencer.sv
// Sequencer for the rolling-average datapath: turns each strobed sample into
// a shift pulse followed by a calc pulse, tracks window fill and runs flushes.
module ra_sequencer
    import ra_pkg::*;
#(
    parameter int RA_SIZE       = RA_SIZE_DEF,
    parameter int BITS_PER_ELEM = BITS_PER_ELEM_DEF,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_data_clk,
    input  logic [BITS_PER_ELEM-1:0]     i_value,
    input  logic                         i_flush,
    output logic                         o_shift_en,
    output logic [BITS_PER_ELEM-1:0]     o_value,
    output logic                         o_start_calc,
    output logic [$clog2(RA_SIZE+1)-1:0] o_fill,
    output logic                         o_valid,
    output logic                         o_busy,
    output logic                         o_overrun
);

    localparam int                FILL_W = $clog2(RA_SIZE + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(RA_SIZE);

    ra_seq_state_t            state_q, state_d;
    logic                     pend_q, pend_d;
    logic                     freq_q, freq_d;
    logic                     ovr_q, ovr_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic [FILL_W-1:0]        cnt_q, cnt_d;
    logic [BITS_PER_ELEM-1:0] value_q, value_d;
    logic [BITS_PER_ELEM-1:0] hold_q, hold_d;
    logic                     rise;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .i_async(i_data_clk),
        .o_rise (rise)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        freq_d  = freq_q;
        ovr_d   = ovr_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        hold_d  = hold_q;

        unique case (state_q)
            IDLE: begin
                if (freq_q || i_flush) begin
                    state_d = FL_SHIFT;
                    fill_d  = '0;
                    cnt_d   = '0;
                    value_d = '0;
                    freq_d  = 1'b0;
                    // Flush discards any queued sample, but a strobe landing
                    // in this very cycle is kept and served afterwards.
                    pend_d  = rise;
                    if (rise) hold_d = i_value;
                end else if (rise || pend_q) begin
                    state_d = SHIFT;
                    value_d = pend_q ? hold_q : i_value;
                    pend_d  = pend_q && rise;
                    if (pend_q && rise) hold_d = i_value;
                end
            end
            SHIFT: state_d = CALC;
            CALC: begin
                state_d = IDLE;
                if (fill_q != FULL) fill_d = fill_q + 1'b1;
            end
            FL_SHIFT: state_d = FL_CALC;
            FL_CALC: begin
                if (cnt_q == FULL) begin
                    state_d = IDLE;
                end else begin
                    state_d = FL_SHIFT;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q == SHIFT || state_q == CALC) begin
            if (i_flush) freq_d = 1'b1;
            if (rise) begin
                if (!pend_q) begin
                    pend_d = 1'b1;
                    hold_d = i_value;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end

        if ((state_q == FL_SHIFT || state_q == FL_CALC) && rise) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            freq_q  <= 1'b0;
            ovr_q   <= 1'b0;
            fill_q  <= '0;
            cnt_q   <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            freq_q  <= freq_d;
            ovr_q   <= ovr_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end

    // Holding register is only meaningful while pend_q is set.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign o_shift_en   = (state_q == SHIFT) || (state_q == FL_SHIFT);
    assign o_start_calc = (state_q == CALC) || (state_q == FL_CALC);
    assign o_value      = value_q;
    assign o_fill       = fill_q;
    assign o_valid      = (fill_q == FULL);
    assign o_busy       = (state_q != IDLE);
    assign o_overrun    = ovr_q;

endmodule
